alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue_if.sv | 50 +++++
 rtl/alu_issue_queue.sv | 146 ++++++++++++++
 tb/tb_alu_issue_queue.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Dispatch, result-broadcast and issue channels of the ALU issue queue.
// The master drives dispatch/CDB/iss_ready; the slave (the queue) answers.
interface alu_issue_queue_if #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  // dispatch
  logic            disp_valid;
  logic            disp_ready;
  logic [3:0]      disp_ctrl;
  logic [TAGW-1:0] disp_rd_tag;
  logic            disp_s1_rdy;
  logic            disp_s2_rdy;
  logic [WORD-1:0] disp_s1_val;
  logic [WORD-1:0] disp_s2_val;
  logic [TAGW-1:0] disp_s1_tag;
  logic [TAGW-1:0] disp_s2_tag;
  // common data bus wakeup
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [WORD-1:0] cdb_val;
  // issue to ALU
  logic            iss_valid;
  logic            iss_ready;
  logic [3:0]      iss_ctrl;
  logic [WORD-1:0] iss_data_1;
  logic [WORD-1:0] iss_data_2;
  logic [TAGW-1:0] iss_rd_tag;
  // occupancy
  logic [CW-1:0]   count;

  modport master (
    output disp_valid, disp_ctrl, disp_rd_tag, disp_s1_rdy, disp_s2_rdy,
           disp_s1_val, disp_s2_val, disp_s1_tag, disp_s2_tag,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    input  disp_ready, iss_valid, iss_ctrl, iss_data_1, iss_data_2,
           iss_rd_tag, count
  );

  modport slave (
    input  disp_valid, disp_ctrl, disp_rd_tag, disp_s1_rdy, disp_s2_rdy,
           disp_s1_val, disp_s2_val, disp_s1_tag, disp_s2_tag,
           cdb_valid, cdb_tag, cdb_val, iss_ready,
    output disp_ready, iss_valid, iss_ctrl, iss_data_1, iss_data_2,
           iss_rd_tag, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue: age-ordered compacting array of DEPTH entries.
// Entries wait for both source operands (captured from the CDB), the
// oldest ready entry is offered to the ALU, and issued entries are
// squeezed out so index 0 is always the oldest.
// Optional macro ISSUE_WAKEUP_BYPASS_EN: an entry woken by the current
// CDB broadcast may issue in the same cycle, with cdb_val forwarded onto
// the matching iss_data_* port.
module alu_issue_queue #(
  parameter int WORD  = 64,
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_issue_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            vld;
    logic [3:0]      ctrl;
    logic [TAGW-1:0] rd_tag;
    logic            s1_rdy;
    logic [TAGW-1:0] s1_tag;
    logic [WORD-1:0] s1_val;
    logic            s2_rdy;
    logic [TAGW-1:0] s2_tag;
    logic [WORD-1:0] s2_val;
  } ent_t;

  ent_t             ent_q   [DEPTH];
  ent_t             ent_d   [DEPTH];
  ent_t             woke    [DEPTH+1];  // top slot is a permanent empty filler for compaction
  ent_t             iss_src [DEPTH];
  ent_t             disp_ent;
  ent_t             sel_ent;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    sel;
  logic             any_rdy;
  logic             do_iss;
  logic             do_disp;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    base;

  // Apply this cycle's CDB broadcast to every waiting source and derive readiness.
  always_comb begin
    woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (bus.cdb_valid && ent_q[i].vld) begin
        if (!ent_q[i].s1_rdy && ent_q[i].s1_tag == bus.cdb_tag) begin
          woke[i].s1_rdy = 1'b1;
          woke[i].s1_val = bus.cdb_val;
        end
        if (!ent_q[i].s2_rdy && ent_q[i].s2_tag == bus.cdb_tag) begin
          woke[i].s2_rdy = 1'b1;
          woke[i].s2_val = bus.cdb_val;
        end
      end
`ifdef ISSUE_WAKEUP_BYPASS_EN
      // issue view already carries the forwarded CDB value
      iss_src[i] = woke[i];
`else
      // woken entries only become visible to issue after the edge
      iss_src[i] = ent_q[i];
`endif
      rdy[i] = iss_src[i].vld && iss_src[i].s1_rdy && iss_src[i].s2_rdy;
    end
  end

  // Pick the oldest (lowest index) ready entry.
  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel     = IW'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign sel_ent = iss_src[sel];

  // Flush kills the offer so a handshake can never appear to complete while clearing.
  assign bus.iss_valid  = any_rdy && !flush;
  assign bus.iss_ctrl   = sel_ent.ctrl;
  assign bus.iss_data_1 = sel_ent.s1_val;
  assign bus.iss_data_2 = sel_ent.s2_val;
  assign bus.iss_rd_tag = sel_ent.rd_tag;

  // A full queue refuses dispatch even if an issue frees a slot this cycle.
  assign bus.disp_ready = (count_q < CW'(DEPTH)) && !flush;
  assign bus.count      = count_q;

  assign do_iss  = bus.iss_valid && bus.iss_ready;
  assign do_disp = bus.disp_valid && bus.disp_ready;

  // Build the incoming entry, catching a wakeup that coincides with dispatch.
  always_comb begin
    disp_ent        = '0;
    disp_ent.vld    = 1'b1;
    disp_ent.ctrl   = bus.disp_ctrl;
    disp_ent.rd_tag = bus.disp_rd_tag;
    disp_ent.s1_rdy = bus.disp_s1_rdy;
    disp_ent.s1_tag = bus.disp_s1_tag;
    disp_ent.s1_val = bus.disp_s1_val;
    disp_ent.s2_rdy = bus.disp_s2_rdy;
    disp_ent.s2_tag = bus.disp_s2_tag;
    disp_ent.s2_val = bus.disp_s2_val;
    if (bus.cdb_valid && !bus.disp_s1_rdy && bus.disp_s1_tag == bus.cdb_tag) begin
      disp_ent.s1_rdy = 1'b1;
      disp_ent.s1_val = bus.cdb_val;
    end
    if (bus.cdb_valid && !bus.disp_s2_rdy && bus.disp_s2_tag == bus.cdb_tag) begin
      disp_ent.s2_rdy = 1'b1;
      disp_ent.s2_val = bus.cdb_val;
    end
  end

  // Next array: compact out the issued entry, then append dispatch at the first free slot.
  always_comb begin
    base    = count_q - CW'(do_iss);
    count_d = count_q + CW'(do_disp) - CW'(do_iss);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (do_iss && i >= int'(sel)) ? woke[i+1] : woke[i];
      if (do_disp && base == CW'(i)) ent_d[i] = disp_ent;
      if (flush) ent_d[i].vld = 1'b0;
    end
    if (flush) count_d = '0;
  end

  // Entry array and occupancy; reset drops every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: dispatch/issue, CDB wakeup, ordering,
// full/flush, same-cycle interactions and asynchronous reset.
module tb_alu_issue_queue;
  localparam int WORD  = 64;
  localparam int DEPTH = 4;
  localparam int TAGW  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.WORD(WORD), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

  alu_issue_queue #(.WORD(WORD), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.disp_valid  = 1'b0;
    bus.disp_ctrl   = '0;
    bus.disp_rd_tag = '0;
    bus.disp_s1_rdy = 1'b0;
    bus.disp_s2_rdy = 1'b0;
    bus.disp_s1_val = '0;
    bus.disp_s2_val = '0;
    bus.disp_s1_tag = '0;
    bus.disp_s2_tag = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_val     = '0;
    bus.iss_ready   = 1'b0;
  endtask

  // one dispatch across one clock edge
  task automatic disp(input logic [3:0] c, input logic [5:0] rd,
                      input logic r1, input logic [63:0] v1, input logic [5:0] t1,
                      input logic r2, input logic [63:0] v2, input logic [5:0] t2);
    bus.disp_valid  = 1'b1;
    bus.disp_ctrl   = c;
    bus.disp_rd_tag = rd;
    bus.disp_s1_rdy = r1;
    bus.disp_s1_val = v1;
    bus.disp_s1_tag = t1;
    bus.disp_s2_rdy = r2;
    bus.disp_s2_val = v2;
    bus.disp_s2_tag = t2;
    tick();
    bus.disp_valid  = 1'b0;
  endtask

  initial begin
    idle_in();
    #12;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // single add, both operands ready
    bus.iss_ready = 1'b1;
    disp(4'h1, 6'd1, 1'b1, 64'd5, 6'd0, 1'b1, 64'd7, 6'd0);
    #1;
    chk("add_valid", 64'(bus.iss_valid), 64'd1);
    chk("add_d1", bus.iss_data_1, 64'd5);
    chk("add_d2", bus.iss_data_2, 64'd7);
    chk("add_ctrl", 64'(bus.iss_ctrl), 64'h1);
    chk("add_rd", 64'(bus.iss_rd_tag), 64'd1);
    chk("add_cnt1", 64'(bus.count), 64'd1);
    tick();
    #1;
    chk("add_cnt0", 64'(bus.count), 64'd0);
    chk("add_idle", 64'(bus.iss_valid), 64'd0);

    // fill with four ops waiting on tag 3, then wake them all
    for (int k = 0; k < 4; k++)
      disp(4'h2, 6'(10 + k), 1'b0, 64'd0, 6'd3, 1'b1, 64'(k + 1), 6'd0);
    #1;
    chk("fill_cnt", 64'(bus.count), 64'd4);
    chk("fill_dready", 64'(bus.disp_ready), 64'd0);
    chk("fill_valid", 64'(bus.iss_valid), 64'd0);
    bus.iss_ready = 1'b0;
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd3;
    bus.cdb_val   = 64'h10;
    tick();
    bus.cdb_valid = 1'b0;
    bus.iss_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("wake_valid", 64'(bus.iss_valid), 64'd1);
      chk("wake_d1", bus.iss_data_1, 64'h10);
      chk("wake_d2", bus.iss_data_2, 64'(k + 1));
      chk("wake_rd", 64'(bus.iss_rd_tag), 64'(10 + k));
      tick();
      #1;
    end
    chk("wake_cnt", 64'(bus.count), 64'd0);

    // younger ready op bypasses older waiting op
    bus.iss_ready = 1'b0;
    disp(4'h3, 6'd20, 1'b0, 64'd0, 6'd9, 1'b1, 64'd2, 6'd0);
    disp(4'h4, 6'd21, 1'b1, 64'h21, 6'd0, 1'b1, 64'd3, 6'd0);
    #1;
    chk("ooo_rd_young", 64'(bus.iss_rd_tag), 64'd21);
    chk("ooo_d1_young", bus.iss_data_1, 64'h21);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    #1;
    chk("ooo_cnt1", 64'(bus.count), 64'd1);
    chk("ooo_wait", 64'(bus.iss_valid), 64'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd9;
    bus.cdb_val   = 64'h99;
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    chk("ooo_old_valid", 64'(bus.iss_valid), 64'd1);
    chk("ooo_rd_old", 64'(bus.iss_rd_tag), 64'd20);
    chk("ooo_d1_old", bus.iss_data_1, 64'h99);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    #1;
    chk("ooo_cnt0", 64'(bus.count), 64'd0);

    // wakeup coinciding with dispatch
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd4;
    bus.cdb_val   = 64'hAB;
    disp(4'h5, 6'd22, 1'b1, 64'd3, 6'd0, 1'b0, 64'd0, 6'd4);
    bus.cdb_valid = 1'b0;
    #1;
    chk("dw_valid", 64'(bus.iss_valid), 64'd1);
    chk("dw_d1", bus.iss_data_1, 64'd3);
    chk("dw_d2", bus.iss_data_2, 64'hAB);
    bus.iss_ready = 1'b1;
    tick();
    #1;
    chk("dw_cnt", 64'(bus.count), 64'd0);

    // dispatch and issue in the same cycle
    bus.iss_ready = 1'b0;
    disp(4'h6, 6'd30, 1'b1, 64'd30, 6'd0, 1'b1, 64'd0, 6'd0);
    bus.iss_ready = 1'b1;
    #1;
    chk("di_rd_first", 64'(bus.iss_rd_tag), 64'd30);
    disp(4'h6, 6'd31, 1'b1, 64'd31, 6'd0, 1'b1, 64'd0, 6'd0);
    bus.iss_ready = 1'b0;
    #1;
    chk("di_cnt", 64'(bus.count), 64'd1);
    chk("di_rd_second", 64'(bus.iss_rd_tag), 64'd31);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;

    // both sources waiting on the same tag
    disp(4'h7, 6'd33, 1'b0, 64'd0, 6'd7, 1'b0, 64'd0, 6'd7);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd7;
    bus.cdb_val   = 64'h77;
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    chk("dual_d1", bus.iss_data_1, 64'h77);
    chk("dual_d2", bus.iss_data_2, 64'h77);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;

    // same-cycle wakeup visibility depends on the bypass build
    disp(4'h8, 6'd34, 1'b0, 64'd0, 6'd2, 1'b1, 64'd5, 6'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd2;
    bus.cdb_val   = 64'd1;
    #1;
`ifdef ISSUE_WAKEUP_BYPASS_EN
    chk("byp_same_valid", 64'(bus.iss_valid), 64'd1);
    chk("byp_same_d1", bus.iss_data_1, 64'd1);
`else
    chk("byp_same_valid", 64'(bus.iss_valid), 64'd0);
`endif
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    chk("byp_next_valid", 64'(bus.iss_valid), 64'd1);
    chk("byp_next_d1", bus.iss_data_1, 64'd1);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;

    // full queue stalled by the ALU, then flushed
    for (int k = 0; k < 4; k++)
      disp(4'h9, 6'(40 + k), 1'b1, 64'(64'h40 + k), 6'd0, 1'b1, 64'd0, 6'd0);
    bus.disp_valid  = 1'b1;
    bus.disp_rd_tag = 6'd50;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 64'(bus.iss_valid), 64'd1);
      chk("stall_rd", 64'(bus.iss_rd_tag), 64'd40);
      chk("stall_d1", bus.iss_data_1, 64'h40);
      chk("stall_dready", 64'(bus.disp_ready), 64'd0);
      tick();
    end
    bus.disp_valid = 1'b0;
    #1;
    chk("stall_cnt", 64'(bus.count), 64'd4);
    flush          = 1'b1;
    bus.iss_ready  = 1'b1;
    bus.disp_valid = 1'b1;
    #1;
    chk("flush_dready", 64'(bus.disp_ready), 64'd0);
    tick();
    flush          = 1'b0;
    bus.disp_valid = 1'b0;
    bus.iss_ready  = 1'b0;
    #1;
    chk("flush_cnt", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.iss_valid), 64'd0);

    // asynchronous reset mid-operation
    disp(4'hA, 6'd60, 1'b1, 64'd1, 6'd0, 1'b1, 64'd1, 6'd0);
    disp(4'hA, 6'd61, 1'b1, 64'd2, 6'd0, 1'b1, 64'd2, 6'd0);
    #1;
    chk("mid_cnt2", 64'(bus.count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(bus.count), 64'd0);
    chk("mid_rst_valid", 64'(bus.iss_valid), 64'd0);
    bus.iss_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_cnt", 64'(bus.count), 64'd0);
    chk("post_rst_dready", 64'(bus.disp_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
